// File: rtl/nec_ir_rx.sv
// NEC IR frame decoder: synchronized ir_in -> key_code/addr_code and sticky {err,rpt,new} flag byte; optional IR_GLITCH_FILTER_EN.
// Latency: flags/keys update 1 clk after the FSM sees a synchronized edge (3 clk from pin, +8 us when filtered); no backpressure.
module nec_ir_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int CHECK_ADDR = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ir_in,
  input  logic       flag_clr,
  output logic [7:0] key_code,
  output logic [7:0] addr_code,
  output logic [7:0] ir_flag
);

  localparam int PRESCALE = CLK_HZ / 1000000;
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [2:0] {
    IDLE, LEAD_LOW, LEAD_HIGH, BIT_LOW, BIT_HIGH, CHECK
  } state_t;

  state_t        state;
  logic [PW-1:0] presc_cnt;
  logic          us_tick;
  logic          sync1, sync2, lvl, lvl_d;
  logic          fall, rise, edge_det, timeout;
  logic [13:0]   dur;
  logic [5:0]    bit_cnt;
  logic [31:0]   shift_reg;
  logic          have_key;
  logic [2:0]    flags;
  logic          cmd_ok, addr_ok;

  function automatic logic in_win(input logic [13:0] d, input logic [13:0] lo, input logic [13:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  assign us_tick = (presc_cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt <= '0;
    end else if (us_tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PW'(1);
    end
  end

  // Line idles high, so the synchronizer resets to 1 to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= ir_in;
      sync2 <= sync1;
    end
  end

`ifdef IR_GLITCH_FILTER_EN
  logic       filt_lvl;
  logic [2:0] filt_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_lvl <= 1'b1;
      filt_cnt <= 3'd0;
    end else if (sync2 == filt_lvl) begin
      filt_cnt <= 3'd0;
    end else if (us_tick) begin
      if (filt_cnt == 3'd7) begin
        filt_lvl <= sync2;
        filt_cnt <= 3'd0;
      end else begin
        filt_cnt <= filt_cnt + 3'd1;
      end
    end
  end

  assign lvl = filt_lvl;
`else
  assign lvl = sync2;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_d <= 1'b1;
    end else begin
      lvl_d <= lvl;
    end
  end

  assign fall     = lvl_d & ~lvl;
  assign rise     = ~lvl_d & lvl;
  assign edge_det = fall | rise;
  assign timeout  = (dur >= 14'd12000) && !edge_det;

  always_ff @(posedge clk) begin
    if (reset) begin
      dur <= 14'd0;
    end else if (edge_det) begin
      dur <= 14'd0;
    end else if (us_tick && (dur != 14'h3FFF)) begin
      dur <= dur + 14'd1;
    end
  end

  // Shift register holds {cmd_n, cmd, addr_n, addr} once 32 bits are in.
  assign cmd_ok  = (shift_reg[23:16] ^ shift_reg[31:24]) == 8'hFF;
  assign addr_ok = (CHECK_ADDR == 0) || ((shift_reg[7:0] ^ shift_reg[15:8]) == 8'hFF);
  assign ir_flag = {5'b00000, flags};

  // flag_clr is written first so any set later in the same cycle takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 6'd0;
      shift_reg <= 32'd0;
      have_key  <= 1'b0;
      flags     <= 3'b000;
      key_code  <= 8'd0;
      addr_code <= 8'd0;
    end else begin
      if (flag_clr) begin
        flags <= 3'b000;
      end
      if (timeout && (state != IDLE) && (state != CHECK)) begin
        state    <= IDLE;
        flags[2] <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (fall) begin
              state <= LEAD_LOW;
            end
          end
          LEAD_LOW: begin
            if (rise) begin
              state <= in_win(dur, 14'd8000, 14'd10000) ? LEAD_HIGH : IDLE;
            end
          end
          LEAD_HIGH: begin
            if (fall) begin
              if (in_win(dur, 14'd4000, 14'd5000)) begin
                state   <= BIT_LOW;
                bit_cnt <= 6'd0;
              end else begin
                state <= IDLE;
                if (in_win(dur, 14'd1750, 14'd2750)) begin
                  if (have_key) begin
                    flags[1] <= 1'b1;
                  end
                end else begin
                  flags[2] <= 1'b1;
                end
              end
            end
          end
          BIT_LOW: begin
            if (rise) begin
              if (in_win(dur, 14'd300, 14'd800)) begin
                state <= BIT_HIGH;
              end else begin
                state    <= IDLE;
                flags[2] <= 1'b1;
              end
            end
          end
          BIT_HIGH: begin
            if (fall) begin
              if (in_win(dur, 14'd300, 14'd800) || in_win(dur, 14'd1300, 14'd2000)) begin
                shift_reg <= {in_win(dur, 14'd1300, 14'd2000), shift_reg[31:1]};
                bit_cnt   <= bit_cnt + 6'd1;
                state     <= (bit_cnt == 6'd31) ? CHECK : BIT_LOW;
              end else begin
                state    <= IDLE;
                flags[2] <= 1'b1;
              end
            end
          end
          CHECK: begin
            state <= IDLE;
            if (cmd_ok && addr_ok) begin
              key_code  <= shift_reg[23:16];
              addr_code <= shift_reg[7:0];
              flags[0]  <= 1'b1;
              have_key  <= 1'b1;
            end else begin
              flags[2] <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nec_ir_rx.sv
// Bench for nec_ir_rx: drives NEC waveforms at 1 us per clock and checks against a frame-level model.
`timescale 1ns/1ps
module tb_nec_ir_rx;

  localparam int CLK_HZ = 1000000;
`ifdef IR_GLITCH_FILTER_EN
  localparam int FILT_DLY = 8;
`else
  localparam int FILT_DLY = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, ir_in, flag_clr;
  logic [7:0] key_code, addr_code, ir_flag;

  int total = 0;
  int bad   = 0;

  // Frame-level reference model state
  logic [7:0] m_key, m_addr;
  logic [2:0] m_flags;
  logic       m_have;
  logic [7:0] snap_key, snap_addr, snap_flag;

  nec_ir_rx #(.CLK_HZ(CLK_HZ), .CHECK_ADDR(0)) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .flag_clr(flag_clr),
    .key_code(key_code), .addr_code(addr_code), .ir_flag(ir_flag)
  );

  always #5 clk = ~clk;

  function automatic int pick(input int nom, input int lo, input int hi, input bit fast);
    if (fast) return int'($urandom_range(hi, lo));
    return nom;
  endfunction

  task automatic model_reset();
    m_key = 8'h00; m_addr = 8'h00; m_flags = 3'b000; m_have = 1'b0;
  endtask

  task automatic model_frame(input logic [31:0] w);
    if ((w[23:16] ^ w[31:24]) == 8'hFF) begin
      m_key = w[23:16]; m_addr = w[7:0]; m_flags[0] = 1'b1; m_have = 1'b1;
    end else begin
      m_flags[2] = 1'b1;
    end
  endtask

  task automatic model_repeat();
    if (m_have) m_flags[1] = 1'b1;
  endtask

  // Holds ir_in at lvl for us microseconds (one clock each), changing at negedges.
  task automatic drive(input logic lvl, input int us);
    ir_in = lvl;
    repeat (us) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic pulse_clr();
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] word, input bit fast, input int rst_bit,
                            input int bad_bit, input bit clr_chk, input bit glitch);
    int ll, bl;
    ll = pick(9000, 8100, 8400, fast);
    if (glitch) begin
      drive(1'b0, 4000); drive(1'b1, 3); drive(1'b0, ll - 4003);
    end else begin
      drive(1'b0, ll);
    end
    drive(1'b1, pick(4500, 4100, 4300, fast));
    for (int i = 0; i < 32; i++) begin
      bl = pick(560, 350, 450, fast);
      if (i == rst_bit) begin
        drive(1'b0, 200);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        snap_key = key_code; snap_addr = addr_code; snap_flag = ir_flag;
        drive(1'b0, bl);
      end else if (glitch) begin
        drive(1'b0, 200); drive(1'b1, 3); drive(1'b0, bl - 200);
      end else begin
        drive(1'b0, bl);
      end
      if (i == bad_bit) begin
        drive(1'b1, 1000); drive(1'b0, 560); drive(1'b1, 200);
        return;
      end
      drive(1'b1, word[i] ? pick(1690, 1350, 1450, fast) : pick(560, 350, 450, fast));
    end
    ir_in = 1'b0;
    if (clr_chk) begin
      // Pin edge -> 2 sync flops -> FSM enters CHECK -> CHECK acts on the 4th posedge.
      repeat (3 + FILT_DLY) @(negedge clk);
      pulse_clr();
      drive(1'b0, 556 - FILT_DLY);
    end else begin
      drive(1'b0, 560);
    end
    drive(1'b1, 200);
  endtask

  task automatic send_repeat(input bit fast);
    drive(1'b0, pick(9000, 8100, 8400, fast));
    drive(1'b1, pick(2250, 2000, 2200, fast));
    drive(1'b0, 560);
    drive(1'b1, 200);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({key_code, addr_code, ir_flag} !== 24'h000000) begin
      bad++; $display("FAIL reset got key=%h addr=%h flag=%h want all 00", key_code, addr_code, ir_flag);
    end
  endtask

  task automatic test_basic();
    logic [31:0] w;
    w = {8'hBA, 8'h45, 8'hFF, 8'h00};
    send_frame(w, 1'b0, -1, -1, 1'b0, 1'b0);
    model_frame(w);
    total++;
    if ({key_code, addr_code, ir_flag} !== {m_key, m_addr, 5'b0, m_flags}) begin
      bad++; $display("FAIL basic got key=%h addr=%h flag=%h want key=%h addr=%h flag=%h",
                      key_code, addr_code, ir_flag, m_key, m_addr, {5'b0, m_flags});
    end
  endtask

  task automatic test_repeat();
    send_repeat(1'b0);
    model_repeat();
    total++;
    if ({key_code, addr_code, ir_flag} !== {m_key, m_addr, 5'b0, m_flags}) begin
      bad++; $display("FAIL repeat got key=%h addr=%h flag=%h want key=%h addr=%h flag=%h",
                      key_code, addr_code, ir_flag, m_key, m_addr, {5'b0, m_flags});
    end
  endtask

  task automatic test_bad_cmd();
    logic [31:0] w;
    w = {8'hBB, 8'h45, 8'h7E, 8'h81};
    send_frame(w, 1'b1, -1, -1, 1'b0, 1'b0);
    model_frame(w);
    total++;
    if ({key_code, addr_code, ir_flag} !== {m_key, m_addr, 5'b0, m_flags}) begin
      bad++; $display("FAIL bad_cmd got key=%h addr=%h flag=%h want key=%h addr=%h flag=%h",
                      key_code, addr_code, ir_flag, m_key, m_addr, {5'b0, m_flags});
    end
  endtask

  task automatic test_bit_err();
    logic [31:0] w;
    pulse_clr();
    m_flags = 3'b000;
    send_frame({8'hA5, 8'h5A, 8'h00, 8'h11}, 1'b1, -1, 3, 1'b0, 1'b0);
    m_flags[2] = 1'b1;
    total++;
    if (ir_flag !== {5'b0, m_flags}) begin
      bad++; $display("FAIL bit_err flag got=%h want=%h", ir_flag, {5'b0, m_flags});
    end
    w = {8'hA5, 8'h5A, 8'h00, 8'h11};
    send_frame(w, 1'b1, -1, -1, 1'b0, 1'b0);
    model_frame(w);
    total++;
    if ({key_code, addr_code, ir_flag} !== {m_key, m_addr, 5'b0, m_flags}) begin
      bad++; $display("FAIL bit_err_recover got key=%h addr=%h flag=%h want key=%h addr=%h flag=%h",
                      key_code, addr_code, ir_flag, m_key, m_addr, {5'b0, m_flags});
    end
  endtask

  task automatic test_clr_at_check();
    logic [31:0] w;
    w = {8'hDE, 8'h21, 8'hFE, 8'h01};
    send_frame(w, 1'b1, -1, -1, 1'b1, 1'b0);
    m_flags = 3'b000;
    model_frame(w);
    total++;
    if ({key_code, addr_code, ir_flag} !== {m_key, m_addr, 5'b0, m_flags}) begin
      bad++; $display("FAIL clr_at_check got key=%h addr=%h flag=%h want key=%h addr=%h flag=%h",
                      key_code, addr_code, ir_flag, m_key, m_addr, {5'b0, m_flags});
    end
  endtask

  task automatic test_flag_clr();
    total++;
    if (ir_flag !== {5'b0, m_flags}) begin
      bad++; $display("FAIL flag_clr_before got=%h want=%h", ir_flag, {5'b0, m_flags});
    end
    pulse_clr();
    m_flags = 3'b000;
    total++;
    if (ir_flag !== 8'h00) begin
      bad++; $display("FAIL flag_clr_after got=%h want=00", ir_flag);
    end
  endtask

  task automatic test_repeat_after_reset();
    do_reset();
    send_repeat(1'b1);
    model_repeat();
    total++;
    if ({key_code, addr_code, ir_flag} !== {m_key, m_addr, 5'b0, m_flags}) begin
      bad++; $display("FAIL repeat_after_reset got key=%h addr=%h flag=%h want key=%h addr=%h flag=%h",
                      key_code, addr_code, ir_flag, m_key, m_addr, {5'b0, m_flags});
    end
  endtask

  task automatic test_timeout();
    drive(1'b0, 9000);
    drive(1'b1, 4500);
    drive(1'b0, 15000);
    drive(1'b1, 200);
    m_flags[2] = 1'b1;
    total++;
    if (ir_flag !== {5'b0, m_flags}) begin
      bad++; $display("FAIL timeout flag got=%h want=%h", ir_flag, {5'b0, m_flags});
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame({8'hE7, 8'h18, 8'hFF, 8'h00}, 1'b1, 17, -1, 1'b0, 1'b0);
    model_reset();
    total++;
    if ({snap_key, snap_addr, snap_flag} !== 24'h000000) begin
      bad++; $display("FAIL reset_mid got key=%h addr=%h flag=%h want all 00", snap_key, snap_addr, snap_flag);
    end
    total++;
    if ({key_code, addr_code, ir_flag} !== {m_key, m_addr, 5'b0, m_flags}) begin
      bad++; $display("FAIL reset_mid_tail got key=%h addr=%h flag=%h want all 00", key_code, addr_code, ir_flag);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] w;
    do_reset();
    w = {8'hE7, 8'h18, 8'hFF, 8'h00};
    send_frame(w, 1'b1, -1, -1, 1'b0, 1'b1);
`ifdef IR_GLITCH_FILTER_EN
    model_frame(w);
    total++;
    if ({key_code, ir_flag} !== {m_key, 5'b0, m_flags}) begin
      bad++; $display("FAIL glitch_filtered got key=%h flag=%h want key=%h flag=%h",
                      key_code, ir_flag, m_key, {5'b0, m_flags});
    end
`else
    total++;
    if (ir_flag[0] !== 1'b0 || key_code !== 8'h00) begin
      bad++; $display("FAIL glitch_unfiltered got key=%h flag=%h want key=00 and new=0", key_code, ir_flag);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [7:0]  c;
    int          r;
    for (int n = 0; n < 3; n++) begin
      r = int'($urandom_range(3, 0));
      if (r == 0) begin
        send_repeat(1'b1);
        model_repeat();
      end else if (r == 1) begin
        pulse_clr();
        m_flags = 3'b000;
      end else begin
        c = 8'($urandom);
        w = {($urandom_range(1, 0) != 0) ? ~c : 8'($urandom), c, 8'($urandom), 8'($urandom)};
        send_frame(w, 1'b1, -1, -1, 1'b0, 1'b0);
        model_frame(w);
      end
      total++;
      if ({key_code, addr_code, ir_flag} !== {m_key, m_addr, 5'b0, m_flags}) begin
        bad++; $display("FAIL random[%0d] op=%0d got key=%h addr=%h flag=%h want key=%h addr=%h flag=%h",
                        n, r, key_code, addr_code, ir_flag, m_key, m_addr, {5'b0, m_flags});
      end
    end
  endtask

  initial begin
    ir_in    = 1'b1;
    flag_clr = 1'b0;
    reset    = 1'b1;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_repeat();
    test_bad_cmd();
    test_bit_err();
    test_clr_at_check();
    test_flag_clr();
    test_repeat_after_reset();
    test_timeout();
    test_reset_mid_frame();
    test_glitch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
